// File: rtl/i_memory_loadable_pkg.sv
// ============================================================================
// i_memory_loadable_pkg : shared widths, fill word and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package i_memory_loadable_pkg;

  localparam int              ISIZE_DEF     = 16;
  localparam int              MEM_SPACE_DEF = 8;
  localparam logic [15:0]     NOP_WORD_DEF  = 16'h0000;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/i_memory_loadable_mem_array.sv
// ============================================================================
// i_mem_array : DEPTH x ISIZE storage, one sync read and one sync write port
// Rev 1.0
// ============================================================================
`default_nettype none

module i_mem_array
  import i_memory_loadable_pkg::*;
#(
  parameter int ISIZE     = ISIZE_DEF,
  parameter int MEM_SPACE = MEM_SPACE_DEF,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [MEM_SPACE-1:0] rd_addr,
  output logic [ISIZE-1:0]     rd_data,
  input  logic                 wr_en,
  input  logic [MEM_SPACE-1:0] wr_addr,
  input  logic [ISIZE-1:0]     wr_data
);

  logic [ISIZE-1:0] mem [DEPTH];

  // Both ports sample the array before the edge, so a same-address
  // read/write returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/i_memory_loadable.sv
// ============================================================================
// i_memory_loadable : loadable instruction memory with power-up NOP sweep
// Rev 1.0
// ============================================================================
`default_nettype none

module i_memory_loadable
  import i_memory_loadable_pkg::*;
#(
  parameter int               ISIZE     = ISIZE_DEF,
  parameter int               MEM_SPACE = MEM_SPACE_DEF,
  parameter int               DEPTH     = 256,
  parameter logic [ISIZE-1:0] NOP_WORD  = ISIZE'(NOP_WORD_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic [MEM_SPACE-1:0] address,
  output logic [ISIZE-1:0]     data_out,
  output logic                 fetch_valid,
  output logic                 fetch_err,
  input  logic                 load_en,
  input  logic [MEM_SPACE-1:0] load_addr,
  input  logic [ISIZE-1:0]     load_data,
  output logic                 ready
);

  localparam logic [MEM_SPACE-1:0] LAST_PTR = MEM_SPACE'(DEPTH - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [MEM_SPACE-1:0]   clear_ptr;
  logic                   fetch_in_range;
  logic                   load_in_range;
  logic                   fetch_ok;
  logic                   rd_en;
  logic [ISIZE-1:0]       rd_data;
  logic                   wr_en;
  logic [MEM_SPACE-1:0]   wr_addr;
  logic [ISIZE-1:0]       wr_data;
  logic                   nop_sel;

  generate
    if (DEPTH == 2 ** MEM_SPACE) begin : g_full_range
      assign fetch_in_range = 1'b1;
      assign load_in_range  = 1'b1;
    end else begin : g_partial_range
      assign fetch_in_range = ({1'b0, address}   < (MEM_SPACE + 1)'(DEPTH));
      assign load_in_range  = ({1'b0, load_addr} < (MEM_SPACE + 1)'(DEPTH));
    end
  endgenerate

  assign fetch_ok = ready & fetch_en;
  assign rd_en    = fetch_ok & fetch_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = load_addr;
    wr_data = load_data;
    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clear_ptr;
        wr_data = NOP_WORD;
        if (clear_ptr == LAST_PTR) begin
          state_d = READY;
        end
      end
      READY: begin
        ready = 1'b1;
        wr_en = load_en & load_in_range;
      end
      default: state_d = CLEAR;
    endcase
  end

  // The pointer parks on the last word once the sweep is done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_ptr <= '0;
    end else if (state_q == CLEAR && clear_ptr != LAST_PTR) begin
      clear_ptr <= clear_ptr + 1'b1;
    end
  end

  // nop_sel masks the array output after reset and for out-of-range fetches,
  // so data_out never shows uninitialised or aliased storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      nop_sel     <= 1'b1;
    end else begin
      fetch_valid <= fetch_ok;
      if (fetch_ok) begin
        fetch_err <= ~fetch_in_range;
        nop_sel   <= ~fetch_in_range;
      end
    end
  end

  assign data_out = nop_sel ? NOP_WORD : rd_data;

  i_mem_array #(
    .ISIZE     (ISIZE),
    .MEM_SPACE (MEM_SPACE),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (address),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_i_memory_loadable.sv
// ============================================================================
// tb_i_memory_loadable : full-depth and DEPTH=200 instances against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i_memory_loadable;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        load_en;
  logic [7:0]  address;
  logic [7:0]  load_addr;
  logic [15:0] load_data;

  logic [15:0] dout  [N];
  logic        valid [N];
  logic        err   [N];
  logic        rdy   [N];

  logic [15:0] mm      [N][256];
  logic [15:0] e_data  [N];
  logic        e_valid [N];
  logic        e_err   [N];
  logic        e_rdy   [N];
  int          e_cnt   [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i_memory_loadable #(.DEPTH(256)) dut0 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .address(address),
    .data_out(dout[0]), .fetch_valid(valid[0]), .fetch_err(err[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ready(rdy[0])
  );

  i_memory_loadable #(.DEPTH(200)) dut1 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .address(address),
    .data_out(dout[1]), .fetch_valid(valid[1]), .fetch_err(err[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ready(rdy[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < 256; a++) mm[k][a] = 16'h0000;
      e_data[k] = 16'h0000; e_valid[k] = 1'b0; e_err[k] = 1'b0;
      e_rdy[k] = 1'b0; e_cnt[k] = 0;
    end
  endtask

  // One clock edge; the model sees the same inputs the DUTs sampled.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (!e_rdy[k]) begin
        e_valid[k] = 1'b0;
        e_cnt[k]++;
        if (e_cnt[k] == dep(k)) e_rdy[k] = 1'b1;
      end else begin
        if (fetch_en) begin
          e_valid[k] = 1'b1;
          if (int'(address) < dep(k)) begin
            e_data[k] = mm[k][address]; e_err[k] = 1'b0;
          end else begin
            e_data[k] = 16'h0000; e_err[k] = 1'b1;
          end
        end else begin
          e_valid[k] = 1'b0;
        end
        if (load_en && int'(load_addr) < dep(k)) mm[k][load_addr] = load_data;
      end
    end
    #1;
  endtask

  task automatic drive(input logic fe, input logic [7:0] a,
                       input logic le, input logic [7:0] la, input logic [15:0] ld);
    fetch_en = fe; address = a; load_en = le; load_addr = la; load_data = ld;
  endtask

  task automatic randomize_inputs(input bit near);
    fetch_en  = 1'($urandom);
    address   = near ? 8'($urandom_range(0, 7)) : 8'($urandom);
    load_en   = 1'($urandom);
    load_addr = near ? 8'($urandom_range(0, 7)) : 8'($urandom);
    load_data = 16'($urandom);
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dout[k] !== 16'h0000 || valid[k] !== 1'b0 || err[k] !== 1'b0 || rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values dut%0d: got data=%h valid=%b err=%b ready=%b, expected 0000/0/0/0",
                 k, dout[k], valid[k], err[k], rdy[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Random fetch/load traffic during the sweep must be ignored.
    for (int i = 0; i < 256; i++) begin
      randomize_inputs(1'b0);
      step();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k] || valid[k] !== e_valid[k] ||
            dout[k] !== e_data[k] || err[k] !== e_err[k]) begin
          errors++;
          $display("FAIL sweep dut%0d cyc%0d: got rdy=%b v=%b d=%h e=%b, expected rdy=%b v=%b d=%h e=%b",
                   k, i + 1, rdy[k], valid[k], dout[k], err[k], e_rdy[k], e_valid[k], e_data[k], e_err[k]);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic test_init_fetch();
    logic [7:0] addrs [3];
    addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, addrs[i], 1'b0, 8'h00, 16'h0000);
      step();
      checks++;
      if (dout[0] !== 16'h0000 || valid[0] !== 1'b1 || err[0] !== 1'b0) begin
        errors++;
        $display("FAIL init_fetch addr=%h: got d=%h v=%b e=%b, expected 0000/1/0",
                 addrs[i], dout[0], valid[0], err[0]);
      end
      checks++;
      if (dout[1] !== e_data[1] || valid[1] !== 1'b1 || err[1] !== e_err[1]) begin
        errors++;
        $display("FAIL init_fetch_d200 addr=%h: got d=%h e=%b, expected d=%h e=%b",
                 addrs[i], dout[1], err[1], e_data[1], e_err[1]);
      end
    end
  endtask

  task automatic test_load_fetch();
    drive(1'b0, 8'h00, 1'b1, 8'h12, 16'hA5A5);
    step();
    drive(1'b1, 8'h12, 1'b0, 8'h00, 16'h0000);
    step();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dout[k] !== 16'hA5A5 || valid[k] !== 1'b1) begin
        errors++;
        $display("FAIL load_fetch dut%0d: got d=%h v=%b, expected a5a5/1", k, dout[k], valid[k]);
      end
    end
  endtask

  task automatic test_read_before_write();
    drive(1'b1, 8'h12, 1'b1, 8'h12, 16'h1234);
    step();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dout[k] !== 16'hA5A5) begin
        errors++;
        $display("FAIL rbw_old dut%0d: got %h expected a5a5", k, dout[k]);
      end
    end
    drive(1'b1, 8'h12, 1'b0, 8'h00, 16'h0000);
    step();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dout[k] !== 16'h1234) begin
        errors++;
        $display("FAIL rbw_new dut%0d: got %h expected 1234", k, dout[k]);
      end
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 8'h40, 1'b1, 8'h05, 16'hBEEF);
    step();
    drive(1'b1, 8'h05, 1'b0, 8'h00, 16'h0000);
    step();
    drive(1'b0, 8'h33, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (dout[k] !== 16'hBEEF || valid[k] !== 1'b0 || err[k] !== 1'b0) begin
          errors++;
          $display("FAIL stall dut%0d cyc%0d: got d=%h v=%b e=%b, expected beef/0/0",
                   k, i, dout[k], valid[k], err[k]);
        end
      end
    end
  endtask

  task automatic test_range();
    drive(1'b1, 8'hC8, 1'b0, 8'h00, 16'h0000);
    step();
    checks++;
    if (dout[1] !== 16'h0000 || err[1] !== 1'b1 || valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL range_oob: got d=%h e=%b v=%b, expected 0000/1/1", dout[1], err[1], valid[1]);
    end
    checks++;
    if (err[0] !== 1'b0 || dout[0] !== e_data[0]) begin
      errors++;
      $display("FAIL range_full: got d=%h e=%b, expected d=%h e=0", dout[0], err[0], e_data[0]);
    end
    drive(1'b0, 8'h00, 1'b1, 8'hC8, 16'hDEAD);
    step();
    // A discarded out-of-range load must not alias onto any in-range word.
    for (int a = 0; a < 256; a += 8) begin
      drive(1'b1, 8'(a), 1'b0, 8'h00, 16'h0000);
      step();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (dout[k] !== e_data[k] || err[k] !== e_err[k]) begin
          errors++;
          $display("FAIL range_scan dut%0d addr=%h: got d=%h e=%b, expected d=%h e=%b",
                   k, a, dout[k], err[k], e_data[k], e_err[k]);
        end
      end
    end
    drive(1'b1, 8'hC8, 1'b0, 8'h00, 16'h0000);
    step();
    checks++;
    if (dout[0] !== 16'hDEAD || dout[1] !== 16'h0000 || err[1] !== 1'b1) begin
      errors++;
      $display("FAIL range_load: got d0=%h d1=%h e1=%b, expected dead/0000/1", dout[0], dout[1], err[1]);
    end
    drive(1'b1, 8'hC7, 1'b0, 8'h00, 16'h0000);
    step();
    checks++;
    if (err[1] !== 1'b0 || valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL range_clear: got e=%b v=%b, expected 0/1", err[1], valid[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(i[0]);
      step();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (dout[k] !== e_data[k] || valid[k] !== e_valid[k] ||
            err[k] !== e_err[k] || rdy[k] !== 1'b1) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: got d=%h v=%b e=%b r=%b, expected d=%h v=%b e=%b r=1",
                   k, i, dout[k], valid[k], err[k], rdy[k], e_data[k], e_valid[k], e_err[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    drive(1'b0, 8'h00, 1'b1, 8'h12, 16'hA5A5);
    step();
    drive(1'b1, 8'hC8, 1'b0, 8'h00, 16'h0000);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dout[k] !== 16'h0000 || valid[k] !== 1'b0 || err[k] !== 1'b0 || rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset_ready dut%0d: got d=%h v=%b e=%b r=%b, expected 0000/0/0/0",
                 k, dout[k], valid[k], err[k], rdy[k]);
      end
    end
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 100; i++) step();
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dout[k] !== 16'h0000 || valid[k] !== 1'b0 || rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset_sweep dut%0d: got d=%h v=%b r=%b, expected 0000/0/0",
                 k, dout[k], valid[k], rdy[k]);
      end
    end
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (rdy[k] !== e_rdy[k]) begin
          errors++;
          $display("FAIL resweep_ready dut%0d cyc%0d: got %b expected %b", k, i + 1, rdy[k], e_rdy[k]);
        end
      end
    end
    drive(1'b1, 8'h12, 1'b0, 8'h00, 16'h0000);
    step();
    drive(1'b1, 8'h05, 1'b0, 8'h00, 16'h0000);
    step();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dout[k] !== 16'h0000 || valid[k] !== 1'b1) begin
        errors++;
        $display("FAIL resweep_cleared dut%0d: got d=%h v=%b, expected 0000/1", k, dout[k], valid[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
    test_reset();
    test_init_fetch();
    test_load_fetch();
    test_read_before_write();
    test_stall();
    test_range();
    test_random();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i_memory_loadable.md
I_MEMORY_LOADABLE -- requirements
Module: i_memory_loadable

Interface
REQ-001 Parameter ISIZE, 16, instruction word width in bits.
REQ-002 Parameter MEM_SPACE, 8, address width; the address space is 2**MEM_SPACE words.
REQ-003 Parameter DEPTH, 256, number of implemented words; DEPTH SHALL be <= 2**MEM_SPACE.
REQ-004 Parameter NOP_WORD, 16'h0000, fill and default value (ISIZE wide).
REQ-005 Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  fetch request; low = stall.
- address  in  MEM_SPACE  fetch address.
- data_out  out  ISIZE  fetched instruction.
- fetch_valid  out  1  data_out holds the result of the previous cycle's accepted fetch.
- fetch_err  out  1  the previous accepted fetch address was >= DEPTH.
- load_en  in  1  program-write strobe.
- load_addr  in  MEM_SPACE  program-write address.
- load_data  in  ISIZE  program-write data.
- ready  out  1  memory is initialised; fetch and load are accepted.

Function
REQ-006 The FSM SHALL have two states, CLEAR and READY; reset enters CLEAR.
REQ-007 CLEAR: writes NOP_WORD to one word per cycle at clear_ptr = 0..DEPTH-1; moves to READY on the cycle after writing word DEPTH-1 (DEPTH cycles in CLEAR).
REQ-008 ready SHALL be 1 exactly when the state is READY.
REQ-009 In CLEAR, fetch_en and load_en SHALL be ignored, and fetch_valid SHALL stay 0.
REQ-010 A fetch is accepted when ready=1 and fetch_en=1.
- data_out SHALL equal mem[address] on the next rising edge (latency 1).
- fetch_valid SHALL be 1 on that edge.
REQ-011 When ready=1 and fetch_en=0 (stall): data_out and fetch_err SHALL hold their values, and fetch_valid SHALL go to 0.
REQ-012 An accepted fetch with address >= DEPTH SHALL return NOP_WORD, with fetch_err=1 and fetch_valid=1.
REQ-013 An accepted fetch with address < DEPTH SHALL clear fetch_err.
REQ-014 A load is accepted when ready=1, load_en=1 and load_addr < DEPTH; it writes load_data into mem[load_addr] on the rising edge.
REQ-015 A load with load_addr >= DEPTH SHALL be discarded silently.
REQ-016 A fetch and a load to the same address in the same cycle SHALL return the old contents (read-before-write); the new value is visible to the next fetch.
REQ-017 A fetch and a load to different addresses in the same cycle SHALL both complete in that cycle.
REQ-018 Address comparisons SHALL be unsigned; when DEPTH = 2**MEM_SPACE, fetch_err SHALL never assert.

Reset
REQ-019 rst asserts asynchronously. While it is high, all of the following SHALL hold:
- data_out = NOP_WORD.
- fetch_valid = 0, fetch_err = 0, ready = 0.
- clear_ptr = 0, state = CLEAR.
REQ-020 Memory contents SHALL NOT be required to change during rst; the CLEAR sweep after release initialises them.
REQ-021 Reset during CLEAR or READY SHALL restart the sweep from word 0; contents loaded earlier are lost after the sweep.
REQ-022 The first fetch SHALL be accepted in the first cycle that ready=1.

Structure
REQ-023 The state encoding (CLEAR, READY) and the default value of NOP_WORD SHALL be placed in the shared define file alongside ISIZE and MEM_SPACE.
REQ-024 The storage array SHALL be a separate sub-module, i_mem_array: one synchronous read port, one synchronous write port, read-before-write, DEPTH x ISIZE.
REQ-025 The top-level block SHALL contain the FSM, the clear counter, the write-port multiplexing (clear sweep versus load), the range checks and the output registers.
REQ-026 The block SHALL NOT contain any file I/O or initial blocks in synthesisable code.

Verification
REQ-027 Release rst with DEPTH=256 -> ready rises exactly 256 cycles later; fetches of 0x00, 0x7F and 0xFF return 16'h0000.
REQ-028 Load 0x12 <- 16'hA5A5, then fetch 0x12 in the next cycle -> data_out=16'hA5A5 and fetch_valid=1 one cycle after the fetch.
REQ-029 Fetch 0x12 and load 0x12 <- 16'h1234 in the same cycle -> the result is 16'hA5A5; a repeat fetch returns 16'h1234.
REQ-030 Fetch 0x05 (holds 16'hBEEF), then hold fetch_en=0 for 3 cycles -> data_out stays 16'hBEEF and fetch_valid=0 for those 3 cycles.
REQ-031 With DEPTH=200, fetch 0xC8 -> data_out=16'h0000 and fetch_err=1; a load to 0xC8 does not change mem; fetch 0xC7 clears fetch_err.
REQ-032 Pulse rst while clear_ptr=100 -> outputs go to reset values immediately; ready rises DEPTH cycles after release, and previously loaded words read 16'h0000.
